// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces active-low push buttons into level and pulse events.
// Latency: DEB_CYCLES+3 rising edges from the first edge that samples a new pin level to the output change.
// Backpressure: none; events are single-cycle pulses that must be consumed as they occur.
//
// Ports:
//   CLK_24MHZ   system clock, all state on its rising edge
//   RESET       asynchronous active-high reset
//   KEY_N       raw active-low button pins (asynchronous)
//   KEY_DOWN    debounced level, 1 = held
//   KEY_PRESS   one-cycle pulse per debounced press (and per auto-repeat)
//   KEY_RELEASE one-cycle pulse per debounced release
//   PRESS_CNT   wrapping count of KEY_PRESS[0] pulses
//
// Optional feature macro: KEY_REPEAT_EN enables hold-to-repeat KEY_PRESS pulses.

module key_debounce #(
  parameter int CLK_FREQ        = 24000000,
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_MS     = 20,
  parameter int DEB_CYCLES      = CLK_FREQ / 1000 * DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                CLK_24MHZ,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY_N,
  output logic [NUM_KEYS-1:0] KEY_DOWN,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_RELEASE,
  output logic [7:0]          PRESS_CNT
);

  // Debounce counter needs at least one bit even when DEB_CYCLES == 1.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

`ifdef KEY_REPEAT_EN
  localparam int REP_DLY  = CLK_FREQ / 1000 * REPEAT_DELAY_MS;
  localparam int REP_RATE = CLK_FREQ / 1000 * REPEAT_RATE_MS;
  localparam int RW       = $clog2(REP_DLY + 1);

  // The repeat counter reloads to REP_DLY-REP_RATE after each repeat, so the
  // rate must not exceed the initial delay.
  if (DEB_CYCLES < 1 || REP_DLY < 1 || REP_RATE < 1 || REP_RATE > REP_DLY) begin : g_bad_param
    $error("key_debounce: invalid debounce/repeat parameters");
  end
`else
  if (DEB_CYCLES < 1 || REPEAT_DELAY_MS < 0 || REPEAT_RATE_MS < 0) begin : g_bad_param
    $error("key_debounce: invalid debounce parameters");
  end
`endif

  // Two-flop synchroniser; reset to the released (high) pin level.
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] k_s;

  always_ff @(posedge CLK_24MHZ or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= KEY_N;
      sync2_q <= sync1_q;
    end
  end

  assign k_s = ~sync2_q;

  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  logic [CW-1:0]       cnt_q   [NUM_KEYS];
  logic [CW-1:0]       cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] down_d;
  logic [NUM_KEYS-1:0] press_d;
  logic [NUM_KEYS-1:0] rel_d;
`ifdef KEY_REPEAT_EN
  logic [RW-1:0]       rcnt_q  [NUM_KEYS];
  logic [RW-1:0]       rcnt_d  [NUM_KEYS];
`endif

  always_comb begin
    down_d  = KEY_DOWN;
    press_d = '0;
    rel_d   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
`ifdef KEY_REPEAT_EN
      // Cleared in every state other than PRESSED, so entry always restarts the delay.
      rcnt_d[k]  = '0;
`endif
      case (state_q[k])
        RELEASED: begin
          if (k_s[k]) begin
            state_d[k] = DEB_PRESS;
            cnt_d[k]   = '0;
          end
        end
        DEB_PRESS: begin
          if (!k_s[k]) begin
            state_d[k] = RELEASED;
          end else if (cnt_q[k] == CW'(DEB_CYCLES - 1)) begin
            state_d[k] = PRESSED;
            down_d[k]  = 1'b1;
            press_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        PRESSED: begin
          if (!k_s[k]) begin
            state_d[k] = DEB_RELEASE;
            cnt_d[k]   = '0;
          end
`ifdef KEY_REPEAT_EN
          else if (rcnt_q[k] == RW'(REP_DLY - 1)) begin
            // Reload so the next repeat fires REP_RATE cycles later.
            press_d[k] = 1'b1;
            rcnt_d[k]  = RW'(REP_DLY - REP_RATE);
          end else begin
            rcnt_d[k] = rcnt_q[k] + 1'b1;
          end
`endif
        end
        DEB_RELEASE: begin
          if (k_s[k]) begin
            state_d[k] = PRESSED;
          end else if (cnt_q[k] == CW'(DEB_CYCLES - 1)) begin
            state_d[k] = RELEASED;
            down_d[k]  = 1'b0;
            rel_d[k]   = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        default: begin
          state_d[k] = RELEASED;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_24MHZ or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= RELEASED;
        cnt_q[k]   <= '0;
`ifdef KEY_REPEAT_EN
        rcnt_q[k]  <= '0;
`endif
      end
      KEY_DOWN    <= '0;
      KEY_PRESS   <= '0;
      KEY_RELEASE <= '0;
      PRESS_CNT   <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
`ifdef KEY_REPEAT_EN
        rcnt_q[k]  <= rcnt_d[k];
`endif
      end
      KEY_DOWN    <= down_d;
      KEY_PRESS   <= press_d;
      KEY_RELEASE <= rel_d;
      // Counts the registered pulse, so the count lags KEY_PRESS[0] by one cycle.
      PRESS_CNT   <= PRESS_CNT + {7'd0, KEY_PRESS[0]};
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed self-checking bench for key_debounce with DEB_CYCLES=4.
// Latency: checks press/release events on the 7th edge after the first low/high sample.
// Backpressure: n/a.

module tb_key_debounce;

  logic       clk;
  logic       rst;
  logic [1:0] key_n;
  logic [1:0] key_down;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [7:0] press_cnt;

  int checks;
  int failures;

  // Observation accumulators, cleared by clr().
  int e_cnt, p_edge, p_num, r_edge, r_num, d_edge, overlap, other, both_num, both_edge, single_num;

`ifdef KEY_REPEAT_EN
  localparam int T_CLK_FREQ = 1000;
`else
  localparam int T_CLK_FREQ = 24000000;
`endif

  key_debounce #(
    .CLK_FREQ        (T_CLK_FREQ),
    .NUM_KEYS        (2),
    .DEBOUNCE_MS     (20),
    .DEB_CYCLES      (4),
    .REPEAT_DELAY_MS (10),
    .REPEAT_RATE_MS  (5)
  ) dut (
    .CLK_24MHZ   (clk),
    .RESET       (rst),
    .KEY_N       (key_n),
    .KEY_DOWN    (key_down),
    .KEY_PRESS   (key_press),
    .KEY_RELEASE (key_release),
    .PRESS_CNT   (press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    e_cnt = 0; p_edge = 0; p_num = 0; r_edge = 0; r_num = 0; d_edge = 0;
    overlap = 0; other = 0; both_num = 0; both_edge = 0; single_num = 0;
  endtask

  // Watch n edges of key k; edge numbers continue across calls until clr().
  task automatic observe(input int n, input int k);
    for (int i = 0; i < n; i++) begin
      tick();
      e_cnt++;
      if (key_press[k]) begin
        p_num++;
        if (p_edge == 0) p_edge = e_cnt;
      end
      if (key_release[k]) begin
        r_num++;
        if (r_edge == 0) r_edge = e_cnt;
      end
      if (key_down[k] && d_edge == 0) d_edge = e_cnt;
      if (key_press[k] && key_release[k]) overlap++;
      if (key_down[1-k] || key_press[1-k] || key_release[1-k]) other++;
      if (key_press == 2'b11) begin
        both_num++;
        if (both_edge == 0) both_edge = e_cnt;
      end else if (key_press != 2'b00) begin
        single_num++;
      end
    end
  endtask

  initial begin
    int total;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    key_n    = 2'b11;
    clr();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_down",    32'(key_down),    32'd0);
    check("reset_press",   32'(key_press),   32'd0);
    check("reset_release", 32'(key_release), 32'd0);
    check("reset_cnt",     32'(press_cnt),   32'd0);
    rst = 1'b0;
    tick();

    // Bounce reject: low 3, high 2, low 3, then high
    clr();
    key_n[0] = 1'b0; observe(3, 0);
    key_n[0] = 1'b1; observe(2, 0);
    key_n[0] = 1'b0; observe(3, 0);
    key_n[0] = 1'b1; observe(15, 0);
    check("bounce_press", 32'(p_num),     32'd0);
    check("bounce_down",  32'(d_edge),    32'd0);
    check("bounce_cnt",   32'(press_cnt), 32'd0);

    // Clean press on key 0
    clr();
    key_n[0] = 1'b0;
    observe(12, 0);
    check("press_edge",   32'(p_edge),    32'd7);
    check("press_pulses", 32'(p_num),     32'd1);
    check("press_down_edge", 32'(d_edge), 32'd7);
    check("press_down",   32'(key_down),  32'd1);
    check("press_cnt",    32'(press_cnt), 32'd1);
    check("press_key1_quiet", 32'(other), 32'd0);

    // Release of key 0
    clr();
    key_n[0] = 1'b1;
    observe(20, 0);
    check("release_edge",   32'(r_edge),   32'd7);
    check("release_pulses", 32'(r_num),    32'd1);
    check("release_no_press", 32'(p_num),  32'd0);
    check("release_overlap", 32'(overlap), 32'd0);
    check("release_down",   32'(key_down), 32'd0);

    // Async reset mid-DEB_PRESS: immediate clear, no late event
    clr();
    key_n[0] = 1'b0;
    observe(4, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_deb_down", 32'(key_down),  32'd0);
    check("rst_mid_deb_cnt",  32'(press_cnt), 32'd0);
    key_n[0] = 1'b1;
    #2 rst = 1'b0;
    clr();
    observe(15, 0);
    check("rst_mid_deb_no_event", 32'(p_num + r_num), 32'd0);

    // Async reset while KEY_PRESS is high
    clr();
    key_n[0] = 1'b0;
    observe(7, 0);
    check("rst_pulse_pre", 32'(key_press), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_pulse_press", 32'(key_press), 32'd0);
    check("rst_pulse_down",  32'(key_down),  32'd0);
    #2 rst = 1'b0;
    // Key still held: must re-qualify from RELEASED in 7 edges
    clr();
    observe(12, 0);
    check("requal_edge",   32'(p_edge),    32'd7);
    check("requal_pulses", 32'(p_num),     32'd1);
    check("requal_cnt",    32'(press_cnt), 32'd1);
    key_n[0] = 1'b1;
    observe(15, 0);

    // Both keys pressed in the same cycle
    clr();
    key_n = 2'b00;
    observe(12, 0);
    check("both_edge",   32'(both_edge),  32'd7);
    check("both_num",    32'(both_num),   32'd1);
    check("both_single", 32'(single_num), 32'd0);
    check("both_down",   32'(key_down),   32'd3);
    key_n = 2'b11;
    clr();
    observe(15, 0);
    check("both_release_down", 32'(key_down), 32'd0);

    // 256 presses after reset: counter wraps back to 0
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    total = 0;
    for (int i = 0; i < 256; i++) begin
      clr();
      key_n[0] = 1'b0; observe(12, 0);
      key_n[0] = 1'b1; observe(12, 0);
      total += p_num;
      if (i == 254) check("wrap_cnt_255", 32'(press_cnt), 32'd255);
    end
    check("wrap_total_pulses", 32'(total),     32'd256);
    check("wrap_cnt_0",        32'(press_cnt), 32'd0);

`ifdef KEY_REPEAT_EN
    // Hold 30 cycles past the first press: repeats at +10,+15,+20,+25,+30
    begin
      int pe[$];
      int drop;
      drop = 0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      key_n[0] = 1'b0;
      for (int e = 1; e <= 37; e++) begin
        tick();
        if (key_press[0]) pe.push_back(e);
        if (e >= 7 && !key_down[0]) drop++;
      end
      check("rep_count", 32'(pe.size()), 32'd6);
      for (int j = 0; j < pe.size() && j < 6; j++)
        check("rep_edge", 32'(pe[j]), 32'(j == 0 ? 7 : 7 + 5 + 5 * j));
      check("rep_down_held", 32'(drop), 32'd0);
      key_n[0] = 1'b1;
      clr();
      observe(15, 0);
      check("rep_stop", 32'(p_num), 32'd0);
      check("rep_release", 32'(r_num), 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
